peak_result_streamer: RTL and testbench
=======================================

PEAK_RESULT_STREAMER -- requirements
Module: peak_result_streamer

Interface
REQ-001 SHALL have parameter NP, default 16: width of one peak result word in bits.
REQ-002 SHALL have parameter PIX, default 200: pixels per frame.
REQ-003 SHALL have parameter IDX_W, default 8: pixel index width; PIX <= 2**IDX_W.
REQ-004 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-005 SHALL have port res, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port frame_done, input, 1: one-cycle strobe; peak_in holds a complete frame.
REQ-007 SHALL have port peak_in, input, NP*PIX: packed peak results; pixel k occupies bits [k*NP +: NP].
REQ-008 SHALL have port out_ready, input, 1: downstream accepts the current beat.
REQ-009 SHALL have port out_valid, output, 1: a beat is presented.
REQ-010 SHALL have port out_data, output, NP: peak value, or checksum on the checksum beat.
REQ-011 SHALL have port out_idx, output, IDX_W: pixel index of the beat; 0 on the checksum beat.
REQ-012 SHALL have port out_sof, output, 1: first beat of a frame.
REQ-013 SHALL have port out_eof, output, 1: last beat of a frame.
REQ-014 SHALL have port overflow, output, 1: sticky; a frame was dropped.
REQ-015 SHALL have port drop_cnt, output, 8: dropped-frame count, saturating at 255.

Function
REQ-016 SHALL hold two frame banks (ping-pong) of PIX x NP bits, each with a full flag.
REQ-017 SHALL, on frame_done with a non-full bank, copy peak_in into that bank in one cycle and set its full flag; the write bank then toggles.
REQ-018 SHALL, on frame_done with both banks full, drop the frame, set overflow, and increment drop_cnt; existing banks stay untouched.
REQ-019 SHALL treat a bank freed by the final handshake in the same cycle as free for a coincident frame_done.
REQ-020 SHALL implement the FSM IDLE -> SEND on any full bank; SEND -> CSUM after the pixel PIX-1 handshake when PEAK_CSUM_EN is defined; otherwise SEND -> IDLE, or SEND -> SEND if the other bank is full.
REQ-021 SHALL have CSUM -> IDLE or SEND under the same condition after its handshake.
REQ-022 SHALL present the first beat one cycle after capture: frame_done at edge t gives out_valid high after edge t+1.
REQ-023 SHALL advance a beat only when out_valid && out_ready; out_data, out_idx, out_sof and out_eof stay stable while stalled.
REQ-024 SHALL assert out_sof only with out_idx==0 on a pixel beat, and out_eof only on the final beat of the frame.
REQ-025 SHALL send pixels in ascending index order; frames go out in capture order.
REQ-026 SHALL clear the read bank's full flag on its final-beat handshake.
REQ-027 SHALL sustain one beat per cycle with out_ready held high, including back-to-back frames with no idle cycle.

Reset
REQ-028 SHALL, while res is low, force out_valid=0, out_data=0, out_idx=0, out_sof=0, out_eof=0, overflow=0, drop_cnt=0, both full flags=0, and FSM=IDLE.
REQ-029 SHALL, when reset is asserted mid-frame, abandon the frame; the next frame starts with out_sof; bank contents need not be cleared.

Configuration
REQ-030 SHALL, with PEAK_CSUM_EN defined, append one beat per frame: out_data = sum of all PIX values modulo 2**NP, out_idx=0, out_eof=1, out_sof=0.
REQ-031 SHALL, without PEAK_CSUM_EN, emit exactly PIX beats per frame with out_eof on pixel PIX-1, and include no checksum logic.

Structure
REQ-032 SHALL take the FSM state enum (IDLE, SEND, CSUM) and the default NP/PIX constants from shared package sifh_pkg.
REQ-033 SHALL place bank storage and full-flag logic in one sub-module, peak_frame_bank; the FSM and counters stay in the top module.

Verification (NP=16, PIX=4, PEAK_CSUM_EN defined unless stated)
REQ-034 SHALL check: peak_in={4,3,2,1} for pixels 3..0, frame_done at cycle 10, out_ready=1 -> beats 1,2,3,4 at cycles 11-14, then checksum 10 at cycle 15 with eof; sof only at cycle 11.
REQ-035 SHALL check: out_ready low for 3 cycles on beat idx=2 -> out_data, out_idx and flags are held and no beat is lost or duplicated.
REQ-036 SHALL check: three frame_done strobes 1 cycle apart with out_ready=0 -> frames 1 and 2 are kept, frame 3 is dropped, overflow=1, drop_cnt=1, and frames 1 then 2 are later emitted intact.
REQ-037 SHALL check: frame_done coincident with the final-beat handshake while the other bank is full -> the frame is accepted and drop_cnt stays 0.
REQ-038 SHALL check: values 0xFFFF x4 -> checksum 0xFFFC; without PEAK_CSUM_EN the frame is exactly 4 beats with eof on idx 3.
REQ-039 SHALL check: res pulsed low during beat idx=1 -> all outputs return to 0 asynchronously; the next frame restarts at idx 0 with sof.

Source files
------------

// File: rtl/sifh_pkg.sv
// Shared constants and FSM state type for the peak result streamer.
// The optional checksum beat is enabled by defining PEAK_CSUM_EN.
package sifh_pkg;

    localparam int unsigned NP_DEF  = 16;
    localparam int unsigned PIX_DEF = 200;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        CSUM
    } stream_state_t;

endpackage

// File: rtl/peak_frame_bank.sv
// Ping-pong frame storage with per-bank full flags and frame drop detection.
// Used by peak_result_streamer (checksum option PEAK_CSUM_EN lives in the top).
module peak_frame_bank
    import sifh_pkg::*;
#(
    parameter int unsigned NP    = NP_DEF,
    parameter int unsigned PIX   = PIX_DEF,
    parameter int unsigned IDX_W = 8
) (
    input  logic              clk,
    input  logic              res,
    input  logic              wr_req,
    input  logic [NP*PIX-1:0] wr_data,
    input  logic              rel,
    input  logic              rd_sel,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [NP-1:0]     rd_data,
    output logic [1:0]        full,
    output logic [1:0]        full_nxt,
    output logic              drop
);

    logic [1:0]        full_q, full_d, rel_mask, avail;
    logic              wr_sel_q;
    logic              accept;
    logic [NP*PIX-1:0] mem_q [2];

    // A bank released by the final handshake this cycle may be refilled at once.
    always_comb begin
        rel_mask         = 2'b00;
        rel_mask[rd_sel] = rel;
        avail            = full_q & ~rel_mask;
        accept           = wr_req && !avail[wr_sel_q];
        drop             = wr_req && !accept;
        full_d           = avail;
        if (accept) begin
            full_d[wr_sel_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            full_q   <= 2'b00;
            wr_sel_q <= 1'b0;
        end else begin
            full_q <= full_d;
            if (accept) begin
                wr_sel_q <= ~wr_sel_q;
            end
        end
    end

    // Storage is not reset; a bank is only read while its full flag is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_sel_q] <= wr_data;
        end
    end

    assign rd_data  = mem_q[rd_sel][NP*int'(rd_idx) +: NP];
    assign full     = full_q;
    assign full_nxt = full_d;

endmodule

// File: rtl/peak_result_streamer.sv
// Streams captured peak frames out as valid/ready beats, one pixel per beat.
// Define PEAK_CSUM_EN to append a modulo-2**NP checksum beat to every frame.
module peak_result_streamer
    import sifh_pkg::*;
#(
    parameter int unsigned NP    = NP_DEF,
    parameter int unsigned PIX   = PIX_DEF,
    parameter int unsigned IDX_W = 8
) (
    input  logic              clk,
    input  logic              res,
    input  logic              frame_done,
    input  logic [NP*PIX-1:0] peak_in,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [NP-1:0]     out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_sof,
    output logic              out_eof,
    output logic              overflow,
    output logic [7:0]        drop_cnt
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(PIX - 1);

    stream_state_t    state_q, state_d;
    logic             rd_sel_q, rd_sel_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             overflow_q;
    logic [7:0]       drop_cnt_q;
    logic             hs, rel, drop;
    logic [1:0]       full, full_nxt;
    logic [NP-1:0]    rd_data;
`ifdef PEAK_CSUM_EN
    logic [NP-1:0]    csum_q, csum_d;
`endif

    assign hs  = out_valid && out_ready;
    assign rel = hs && out_eof;

    peak_frame_bank #(
        .NP    (NP),
        .PIX   (PIX),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk      (clk),
        .res      (res),
        .wr_req   (frame_done),
        .wr_data  (peak_in),
        .rel      (rel),
        .rd_sel   (rd_sel_q),
        .rd_idx   (idx_q),
        .rd_data  (rd_data),
        .full     (full),
        .full_nxt (full_nxt),
        .drop     (drop)
    );

    // Outputs depend only on registered state, so they hold while stalled.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        out_sof   = 1'b0;
        out_eof   = 1'b0;
        case (state_q)
            SEND: begin
                out_valid = 1'b1;
                out_data  = rd_data;
                out_idx   = idx_q;
                out_sof   = (idx_q == '0);
`ifndef PEAK_CSUM_EN
                out_eof   = (idx_q == LastIdx);
`endif
            end
`ifdef PEAK_CSUM_EN
            CSUM: begin
                out_valid = 1'b1;
                out_data  = csum_q;
                out_eof   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        rd_sel_d = rd_sel_q;
        idx_d    = idx_q;
        case (state_q)
            IDLE: begin
                if (|full) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (hs) begin
                    if (idx_q == LastIdx) begin
                        idx_d = '0;
`ifdef PEAK_CSUM_EN
                        state_d = CSUM;
`else
                        rd_sel_d = ~rd_sel_q;
                        state_d  = full_nxt[~rd_sel_q] ? SEND : IDLE;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef PEAK_CSUM_EN
            CSUM: begin
                if (hs) begin
                    rd_sel_d = ~rd_sel_q;
                    state_d  = full_nxt[~rd_sel_q] ? SEND : IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

`ifdef PEAK_CSUM_EN
    // Running sum restarts on pixel 0 so it is complete by the checksum beat.
    always_comb begin
        csum_d = csum_q;
        if (state_q == SEND && hs) begin
            csum_d = ((idx_q == '0) ? '0 : csum_q) + rd_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q    <= IDLE;
            rd_sel_q   <= 1'b0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
`ifdef PEAK_CSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rd_sel_q <= rd_sel_d;
            idx_q    <= idx_d;
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_q <= drop_cnt_q + 8'd1;
                end
            end
`ifdef PEAK_CSUM_EN
            csum_q <= csum_d;
`endif
        end
    end

    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_peak_result_streamer.sv
// Scoreboard bench for peak_result_streamer (NP=16, PIX=4); follows PEAK_CSUM_EN if defined.
module tb_peak_result_streamer;

    localparam int NP    = 16;
    localparam int PIX   = 4;
    localparam int IDX_W = 8;
`ifdef PEAK_CSUM_EN
    localparam int BEATS = PIX + 1;
    localparam bit CSUM  = 1'b1;
`else
    localparam int BEATS = PIX;
    localparam bit CSUM  = 1'b0;
`endif

    typedef struct packed {
        logic [NP-1:0]    data;
        logic [IDX_W-1:0] idx;
        logic             sof;
        logic             eof;
    } beat_t;

    logic              clk = 1'b0;
    logic              res = 1'b1;
    logic              frame_done = 1'b0;
    logic [NP*PIX-1:0] peak_in = '0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [NP-1:0]     out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_sof;
    logic              out_eof;
    logic              overflow;
    logic [7:0]        drop_cnt;

    int checks = 0;
    int failures = 0;
    int accepted = 0;
    int completed = 0;
    int drops = 0;
    int cyc = 0;
    int last_eof_cyc = 0;
    beat_t exp_q[$];

    peak_result_streamer #(
        .NP    (NP),
        .PIX   (PIX),
        .IDX_W (IDX_W)
    ) dut (
        .clk        (clk),
        .res        (res),
        .frame_done (frame_done),
        .peak_in    (peak_in),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a frame is PIX beats in index order, plus an optional wrapped sum.
    task automatic push_frame(input logic [NP*PIX-1:0] vec);
        logic [NP-1:0] sum = '0;
        for (int k = 0; k < PIX; k++) begin
            beat_t b;
            b.data = vec[k*NP +: NP];
            b.idx  = IDX_W'(k);
            b.sof  = (k == 0);
            b.eof  = !CSUM && (k == PIX - 1);
            sum    = sum + b.data;
            exp_q.push_back(b);
        end
        if (CSUM) begin
            beat_t c;
            c.data = sum;
            c.idx  = '0;
            c.sof  = 1'b0;
            c.eof  = 1'b1;
            exp_q.push_back(c);
        end
    endtask

    // Two frames may be outstanding; a frame finishing on this very edge frees a slot.
    task automatic send_frame(input logic [NP*PIX-1:0] vec);
        bit final_hs;
        final_hs   = out_valid && out_ready && out_eof;
        peak_in    = vec;
        frame_done = 1'b1;
        if ((accepted - completed) < 2 || final_hs) begin
            accepted++;
            push_frame(vec);
        end else begin
            drops++;
        end
        tick();
        frame_done = 1'b0;
    endtask

    task automatic do_reset();
        res = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_idx", 32'(out_idx), 0);
        chk("rst_sof", 32'(out_sof), 0);
        chk("rst_eof", 32'(out_eof), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
        frame_done = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.delete();
        accepted  = 0;
        completed = 0;
        drops     = 0;
        #1;
        res = 1'b1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((completed < accepted || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_drained"}, 32'(completed == accepted && exp_q.size() == 0), 1);
    endtask

    function automatic logic [NP*PIX-1:0] rand_frame();
        logic [NP*PIX-1:0] v;
        for (int k = 0; k < PIX; k++) v[k*NP +: NP] = NP'($urandom);
        return v;
    endfunction

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    beat_t held;
    bit    stalled = 1'b0;
    always @(negedge clk) begin
        if (!res) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_data", 32'(out_data), 32'(held.data));
                chk("hold_idx", 32'(out_idx), 32'(held.idx));
                chk("hold_sof", 32'(out_sof), 32'(held.sof));
                chk("hold_eof", 32'(out_eof), 32'(held.eof));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual data=%0h idx=%0d required none",
                             out_data, out_idx);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", 32'(out_data), 32'(e.data));
                    chk("beat_idx", 32'(out_idx), 32'(e.idx));
                    chk("beat_sof", 32'(out_sof), 32'(e.sof));
                    chk("beat_eof", 32'(out_eof), 32'(e.eof));
                end
                if (out_eof) begin
                    completed++;
                    last_eof_cyc = cyc;
                end
            end
            stalled   = out_valid && !out_ready;
            held.data = out_data;
            held.idx  = out_idx;
            held.sof  = out_sof;
            held.eof  = out_eof;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cap_cyc;
        int n;
        #3;
        do_reset();

        // Basic frame: latency, order, back-to-back beats.
        out_ready = 1'b1;
        send_frame({16'd4, 16'd3, 16'd2, 16'd1});
        cap_cyc = cyc;
        chk("t1_idle_after_capture", 32'(out_valid), 0);
        tick();
        chk("t1_first_valid", 32'(out_valid), 1);
        chk("t1_first_sof", 32'(out_sof), 1);
        chk("t1_first_idx", 32'(out_idx), 0);
        wait_done("t1", 50);
        chk("t1_eof_cycle", 32'(last_eof_cyc), 32'(cap_cyc + BEATS));
        chk("t1_overflow", 32'(overflow), 0);

        // Stall three cycles on pixel 2.
        send_frame(rand_frame());
        n = 0;
        while (!(out_valid && out_idx == 2) && n < 20) begin
            tick();
            n++;
        end
        chk("t2_reached_idx2", 32'(out_valid && out_idx == 2), 1);
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        wait_done("t2", 50);

        // Three frames with downstream blocked: the third is dropped.
        out_ready = 1'b0;
        repeat (3) send_frame(rand_frame());
        chk("t3_overflow", 32'(overflow), 1);
        chk("t3_drop_cnt", 32'(drop_cnt), 1);
        chk("t3_model_drops", 32'(drop_cnt), 32'(drops));
        out_ready = 1'b1;
        wait_done("t3", 100);

        // Frame arriving on the final handshake while the other bank is full.
        do_reset();
        out_ready = 1'b0;
        repeat (2) send_frame(rand_frame());
        out_ready = 1'b1;
        n = 0;
        while (!(out_valid && out_eof) && n < 20) begin
            tick();
            n++;
        end
        send_frame(rand_frame());
        chk("t4_accepted", 32'(accepted), 3);
        wait_done("t4", 100);
        chk("t4_drop_cnt", 32'(drop_cnt), 0);
        chk("t4_overflow", 32'(overflow), 0);

        // All-ones frame: checksum wraps.
        send_frame({4{16'hFFFF}});
        wait_done("t5", 50);

        // Reset in the middle of a frame, then a clean frame.
        send_frame(rand_frame());
        n = 0;
        while (!(out_valid && out_idx == 1) && n < 20) begin
            tick();
            n++;
        end
        #2;
        do_reset();
        send_frame(rand_frame());
        tick();
        chk("t6_restart_idx", 32'(out_idx), 0);
        chk("t6_restart_sof", 32'(out_sof), 1);
        wait_done("t6", 50);

        // Random traffic with random backpressure.
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 5)) begin
                out_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            send_frame(rand_frame());
        end
        out_ready = 1'b1;
        wait_done("rand", 1000);
        chk("rand_drop_cnt", 32'(drop_cnt), 32'((drops > 255) ? 255 : drops));
        chk("rand_overflow", 32'(overflow), 32'(drops > 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
